// File: rtl/commutation_pkg.sv
// Shared constants for the commutation scheduler: FSM states, result tags,
// midscale target value and default phase offsets.
package commutation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_ISSUE_A,
    ST_ISSUE_B,
    ST_ISSUE_C,
    ST_DRAIN,
    ST_COMMIT,
    ST_CAL
  } state_t;

  localparam logic [1:0] TAG_A   = 2'd0;
  localparam logic [1:0] TAG_B   = 2'd1;
  localparam logic [1:0] TAG_C   = 2'd2;
  localparam logic [1:0] TAG_CAL = 2'd3;

  localparam logic [15:0] TGT_ZERO = 16'h4000;

  localparam logic [10:0] DEFAULT_PHASE_B_OFS = 11'd683;
  localparam logic [10:0] DEFAULT_PHASE_C_OFS = 11'd1365;

endpackage

// File: rtl/result_tag_pipe.sv
// Delay line of {valid, tag} matching the latency of the shared sine/multiply
// pipeline, so each returning result can be routed to its destination.
module result_tag_pipe #(
  parameter int PIPE_LAT = 10
) (
  input  logic       c,
  input  logic       rst_n,
  input  logic       push,
  input  logic [1:0] push_tag,
  output logic       pop_valid,
  output logic [1:0] pop_tag
);

  logic [PIPE_LAT-1:0]      valid_sr;
  logic [PIPE_LAT-1:0][1:0] tag_sr;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
      tag_sr   <= '0;
    end else begin
      valid_sr <= {valid_sr[PIPE_LAT-2:0], push};
      tag_sr   <= {tag_sr[PIPE_LAT-2:0], push_tag};
    end
  end

  assign pop_valid = valid_sr[PIPE_LAT-1];
  assign pop_tag   = tag_sr[PIPE_LAT-1];

endmodule

// File: rtl/commutation_scheduler.sv
// Issues phase A/B/C angles once per commutation frame into the shared sine
// pipeline, gathers the results and commits them atomically; grants
// calibration lookups between frames.
module commutation_scheduler
  import commutation_pkg::*;
#(
  parameter int          PIPE_LAT    = 10,
  parameter logic [10:0] PHASE_B_OFS = DEFAULT_PHASE_B_OFS,
  parameter logic [10:0] PHASE_C_OFS = DEFAULT_PHASE_C_OFS
) (
  input  logic        c,
  input  logic        rst_n,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] menc_raw,
  input  logic [15:0] stator_offset,
  input  logic        cal_req,
  input  logic [10:0] cal_angle,
  output logic        cal_ack,
  output logic [10:0] angle_z,
  output logic        issue,
  input  logic [15:0] tgt,
  output logic [47:0] current_targets,
  output logic        targets_valid,
  output logic [15:0] cal_result,
  output logic        cal_valid,
  output logic        busy,
  output logic        overrun
);

  state_t      state, state_nxt;
  logic [10:0] base;
  logic [15:0] shadow_a, shadow_b, shadow_c;
  logic        pending;
  logic [1:0]  push_tag;
  logic        pop_valid;
  logic [1:0]  pop_tag;
  logic        start_busy, consume_pending, last_result;
  logic        unused_hi;

  assign unused_hi = ^{menc_raw[15:11], stator_offset[15:11]};

  result_tag_pipe #(.PIPE_LAT(PIPE_LAT)) u_tag_pipe (
    .c        (c),
    .rst_n    (rst_n),
    .push     (issue),
    .push_tag (push_tag),
    .pop_valid(pop_valid),
    .pop_tag  (pop_tag)
  );

  assign busy            = (state != ST_IDLE) && (state != ST_CAL);
  assign start_busy      = start && en && busy;
  assign consume_pending = pending && ((state == ST_COMMIT) || (state == ST_IDLE));
  assign last_result     = (state == ST_DRAIN) && pop_valid && (pop_tag == TAG_C);

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    issue         = 1'b0;
    angle_z       = base;
    push_tag      = TAG_A;
    cal_ack       = 1'b0;
    targets_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((start && en) || pending) state_nxt = ST_SNAP;
        else if (cal_req)             state_nxt = ST_CAL;
      end
      ST_SNAP: state_nxt = ST_ISSUE_A;
      ST_ISSUE_A: begin
        issue     = 1'b1;
        push_tag  = TAG_A;
        state_nxt = ST_ISSUE_B;
      end
      ST_ISSUE_B: begin
        issue     = 1'b1;
        angle_z   = base + PHASE_B_OFS;
        push_tag  = TAG_B;
        state_nxt = ST_ISSUE_C;
      end
      ST_ISSUE_C: begin
        issue     = 1'b1;
        angle_z   = base + PHASE_C_OFS;
        push_tag  = TAG_C;
        state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (last_result) state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        targets_valid = 1'b1;
        // A queued frame restarts without an idle cycle; otherwise a waiting
        // calibration is granted straight away.
        if (pending)      state_nxt = ST_SNAP;
        else if (cal_req) state_nxt = ST_CAL;
        else              state_nxt = ST_IDLE;
      end
      ST_CAL: begin
        issue     = 1'b1;
        angle_z   = cal_angle;
        push_tag  = TAG_CAL;
        cal_ack   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) base <= '0;
    else if (state == ST_SNAP) base <= menc_raw[10:0] + stator_offset[10:0];
  end

  // The phase C result bypasses its shadow so the new targets are visible in
  // the same cycle as the targets_valid pulse.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      shadow_a        <= TGT_ZERO;
      shadow_b        <= TGT_ZERO;
      shadow_c        <= TGT_ZERO;
      cal_result      <= TGT_ZERO;
      cal_valid       <= 1'b0;
      current_targets <= {3{TGT_ZERO}};
    end else begin
      cal_valid <= 1'b0;
      if (pop_valid) begin
        case (pop_tag)
          TAG_A:   shadow_a <= tgt;
          TAG_B:   shadow_b <= tgt;
          TAG_C:   shadow_c <= tgt;
          default: begin
            cal_result <= tgt;
            cal_valid  <= 1'b1;
          end
        endcase
      end
      if (last_result) current_targets <= {tgt, shadow_b, shadow_a};
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (start_busy) begin
      if (pending && !consume_pending) overrun <= 1'b1;
      else                             pending <= 1'b1;
    end else if (consume_pending) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_commutation_scheduler.sv
// Scoreboard bench for commutation_scheduler: a lookup-table model of the sine
// pipeline answers issued angles, and a monitor checks every DUT output.
module tb_commutation_scheduler;

  localparam int PIPE_LAT = 10;
  localparam int B_OFS    = 683;
  localparam int C_OFS    = 1365;

  logic        c = 1'b0;
  logic        rst_n = 1'b0;
  logic        en, start, cal_req;
  logic [15:0] menc_raw, stator_offset, tgt;
  logic [10:0] cal_angle;
  logic        cal_ack, issue, targets_valid, cal_valid, busy, overrun;
  logic [10:0] angle_z;
  logic [47:0] current_targets;
  logic [15:0] cal_result;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic [15:0] lut [2048];
  logic [16:0] resp [64];

  logic [10:0] exp_angle_q [$];
  logic [47:0] exp_tgt_q   [$];
  logic [15:0] exp_cal_q   [$];

  commutation_scheduler #(.PIPE_LAT(PIPE_LAT)) dut (
    .c              (c),
    .rst_n          (rst_n),
    .en             (en),
    .start          (start),
    .menc_raw       (menc_raw),
    .stator_offset  (stator_offset),
    .cal_req        (cal_req),
    .cal_angle      (cal_angle),
    .cal_ack        (cal_ack),
    .angle_z        (angle_z),
    .issue          (issue),
    .tgt            (tgt),
    .current_targets(current_targets),
    .targets_valid  (targets_valid),
    .cal_result     (cal_result),
    .cal_valid      (cal_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 c = ~c;

  always @(posedge c) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic flagUnexpected(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s unexpected output at cycle %0d", name, cyc);
  endtask

  // Sine pipeline model: answer each issued angle PIPE_LAT cycles later;
  // idle cycles carry random junk so a mistimed sample is visible.
  always @(negedge c) begin
    tgt = resp[cyc % 64][16] ? resp[cyc % 64][15:0] : 16'($urandom);
    resp[cyc % 64] = '0;
    if (issue === 1'b1) resp[(cyc + PIPE_LAT) % 64] = {1'b1, lut[angle_z]};
  end

  // Monitor: pop expectations whenever the DUT presents an output.
  always @(negedge c) begin
    if (rst_n) begin
      if (issue) begin
        if (exp_angle_q.size() == 0) flagUnexpected("issue");
        else checkOutput("angle_z", 64'(angle_z), 64'(exp_angle_q.pop_front()));
      end
      if (targets_valid) begin
        if (exp_tgt_q.size() == 0) flagUnexpected("targets_valid");
        else checkOutput("current_targets", 64'(current_targets), 64'(exp_tgt_q.pop_front()));
      end
      if (cal_valid) begin
        if (exp_cal_q.size() == 0) flagUnexpected("cal_valid");
        else checkOutput("cal_result", 64'(cal_result), 64'(exp_cal_q.pop_front()));
      end
    end
  end

  task automatic pushFrame(input logic [15:0] m, input logic [15:0] o);
    int a, b, cc;
    a  = (int'(m) % 2048 + int'(o) % 2048) % 2048;
    b  = (a + B_OFS) % 2048;
    cc = (a + C_OFS) % 2048;
    exp_angle_q.push_back(11'(a));
    exp_angle_q.push_back(11'(b));
    exp_angle_q.push_back(11'(cc));
    exp_tgt_q.push_back({lut[cc], lut[b], lut[a]});
  endtask

  task automatic pushCal(input logic [10:0] ca);
    exp_angle_q.push_back(ca);
    exp_cal_q.push_back(lut[ca]);
  endtask

  // Pulses start for one cycle (optionally with a calibration request);
  // t0 is the cycle in which start is high.
  task automatic applyStimulus(input logic [15:0] m, input logic [15:0] o,
                               input bit with_cal, input logic [10:0] ca,
                               output int t0);
    @(posedge c); #1;
    menc_raw      = m;
    stator_offset = o;
    start         = 1'b1;
    t0            = cyc;
    pushFrame(m, o);
    if (with_cal) begin
      cal_req   = 1'b1;
      cal_angle = ca;
      pushCal(ca);
    end
    @(posedge c); #1;
    start = 1'b0;
  endtask

  task automatic waitCalAck(output int at_cyc);
    bit seen = 0;
    at_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge c); #1;
      if (cal_ack) begin
        seen    = 1;
        at_cyc  = cyc;
        cal_req = 1'b0;
        break;
      end
    end
    checkOutput("cal_ack_seen", 64'(seen), 64'd1);
    cal_req = 1'b0;
  endtask

  task automatic requestCal(input logic [10:0] ca);
    int dummy;
    @(posedge c); #1;
    cal_req   = 1'b1;
    cal_angle = ca;
    pushCal(ca);
    waitCalAck(dummy);
  endtask

  task automatic waitQuiet();
    bit done = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge c); #1;
      if (!busy && exp_angle_q.size() == 0 && exp_tgt_q.size() == 0 &&
          exp_cal_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    checkOutput("quiet_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0, at;
    bit seen;
    logic [15:0] m, o;

    en = 1'b1; start = 1'b0; cal_req = 1'b0; cal_angle = '0;
    menc_raw = '0; stator_offset = '0; tgt = '0;
    for (int i = 0; i < 2048; i++) lut[i] = 16'($urandom);
    for (int i = 0; i < 64; i++) resp[i] = '0;
    lut[300]  = 16'h4100;
    lut[983]  = 16'h3F00;
    lut[1665] = 16'h4000;

    repeat (3) @(posedge c);
    #1;
    checkOutput("reset_targets", 64'(current_targets), 64'h4000_4000_4000);
    checkOutput("reset_cal_result", 64'(cal_result), 64'h4000);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_overrun", 64'(overrun), 64'd0);
    checkOutput("reset_strobes", 64'({issue, targets_valid, cal_valid, cal_ack}), 64'd0);
    rst_n = 1'b1;

    // Basic frame with known table values and commit timing.
    applyStimulus(16'd300, 16'd0, 1'b0, 11'd0, t0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge c); #1;
      if (targets_valid) begin seen = 1; break; end
    end
    checkOutput("commit_seen", 64'(seen), 64'd1);
    checkOutput("commit_cycle", 64'(cyc - t0), 64'(5 + PIPE_LAT));
    checkOutput("commit_value", 64'(current_targets), 64'h4000_3F00_4100);
    waitQuiet();

    // Angle wrap with junk in the unused upper bits.
    applyStimulus({5'($urandom), 11'd2000}, {5'($urandom), 11'd100}, 1'b0, 11'd0, t0);
    waitQuiet();

    // Encoder changing right after SNAP must not affect the frame.
    applyStimulus(16'($urandom), 16'($urandom), 1'b0, 11'd0, t0);
    @(posedge c); #1;
    menc_raw = 16'($urandom);
    stator_offset = 16'($urandom);
    waitQuiet();

    // Frame and calibration together: frame first, cal right after COMMIT.
    applyStimulus(16'($urandom), 16'($urandom), 1'b1, 11'd512, t0);
    waitCalAck(at);
    checkOutput("cal_ack_cycle", 64'(at - t0), 64'(6 + PIPE_LAT));
    waitQuiet();

    // Pending start in cycle 3, a further start sets overrun.
    m = 16'($urandom); o = 16'($urandom);
    applyStimulus(m, o, 1'b0, 11'd0, t0);
    while (cyc < t0 + 3) begin @(posedge c); #1; end
    start = 1'b1;
    pushFrame(m, o);
    @(posedge c); #1;
    start = 1'b0;
    checkOutput("overrun_after_pending", 64'(overrun), 64'd0);
    while (cyc < t0 + 6) begin @(posedge c); #1; end
    start = 1'b1;
    @(posedge c); #1;
    start = 1'b0;
    checkOutput("overrun_set", 64'(overrun), 64'd1);
    while (cyc < t0 + 6 + PIPE_LAT) begin @(posedge c); #1; end
    checkOutput("back_to_back_busy", 64'(busy), 64'd1);
    waitQuiet();

    // Asynchronous reset mid-frame discards in-flight results.
    applyStimulus(16'($urandom), 16'($urandom), 1'b0, 11'd0, t0);
    while (cyc < t0 + 3 + PIPE_LAT) begin @(posedge c); #1; end
    rst_n = 1'b0;
    exp_tgt_q.delete();
    #1;
    checkOutput("async_reset_targets", 64'(current_targets), 64'h4000_4000_4000);
    checkOutput("async_reset_overrun", 64'(overrun), 64'd0);
    checkOutput("async_reset_busy", 64'(busy), 64'd0);
    checkOutput("async_reset_cal", 64'(cal_result), 64'h4000);
    repeat (2) @(posedge c);
    #1;
    rst_n = 1'b1;
    repeat (2 * PIPE_LAT) @(posedge c);
    #1;
    checkOutput("post_reset_targets", 64'(current_targets), 64'h4000_4000_4000);
    checkOutput("post_reset_cal", 64'(cal_result), 64'h4000);

    // Disabled start is ignored.
    en = 1'b0;
    @(posedge c); #1;
    start = 1'b1;
    @(posedge c); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("disabled_busy", 64'(busy), 64'd0);
      @(posedge c); #1;
    end
    checkOutput("disabled_overrun", 64'(overrun), 64'd0);
    en = 1'b1;

    // Randomised mix of frames and calibration lookups.
    for (int n = 0; n < 12; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) @(posedge c);
      if (kind == 1) requestCal(11'($urandom));
      else begin
        applyStimulus(16'($urandom), 16'($urandom), kind == 2, 11'($urandom), t0);
        if (kind == 2) waitCalAck(at);
      end
      waitQuiet();
    end

    checkOutput("angle_queue_empty", 64'(exp_angle_q.size()), 64'd0);
    checkOutput("target_queue_empty", 64'(exp_tgt_q.size()), 64'd0);
    checkOutput("cal_queue_empty", 64'(exp_cal_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
